// File: rtl/boost_charge_controller_if.sv
// Boost charge controller signal bundle.
// master : drives the charge request and ADC sample stream, observes status.
// slave  : the controller; consumes samples, drives gate and status.
//   enable, target_v[11:0]        charge request and bus setpoint (ADC codes)
//   new_data, valid_data          fresh-sample strobe, stream health flag
//   data_a[11:0], data_b[11:0]    coil current and bus voltage samples
//   gate, charging, at_target     switch drive and state flags
//   fault, fault_code[1:0]        00 none, 01 overcurrent, 10 overvoltage, 11 data loss
interface boost_charge_controller_if;
  logic        enable;
  logic [11:0] target_v;
  logic        new_data;
  logic        valid_data;
  logic [11:0] data_a;
  logic [11:0] data_b;
  logic        gate;
  logic        charging;
  logic        at_target;
  logic        fault;
  logic [1:0]  fault_code;

  modport master (
    output enable, target_v, new_data, valid_data, data_a, data_b,
    input  gate, charging, at_target, fault, fault_code
  );

  modport slave (
    input  enable, target_v, new_data, valid_data, data_a, data_b,
    output gate, charging, at_target, fault, fault_code
  );
endinterface

// File: rtl/boost_charge_controller.sv
// Boost converter charge controller.
// Ramps a PWM duty cycle one step per accepted ADC sample while charging,
// parks the switch once the bus reaches target (with hysteresis for the
// return to charging) and latches faults for overcurrent, overvoltage and
// loss of the sample stream.
// Ports: clk (rising edge), rst (synchronous, active high),
//        bus (slave modport of boost_charge_controller_if).
module boost_charge_controller #(
  parameter int PWM_PERIOD = 1000,
  parameter int MAX_DUTY   = 600,
  parameter int DUTY_STEP  = 8,
  parameter int HYST       = 20,
  parameter int OC_LIMIT   = 3000,
  parameter int OV_MARGIN  = 100
) (
  input logic                       clk,
  input logic                       rst,
  boost_charge_controller_if.slave  bus
);
  // Counter and duty share a width; MAX_DUTY < PWM_PERIOD so duty always fits.
  localparam int CW = $clog2(PWM_PERIOD + 1);

  typedef enum logic [1:0] {S_IDLE, S_CHARGE, S_HOLD, S_FAULT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] duty_q, duty_d;      // pending duty, ramped by samples
  logic [CW-1:0] act_q, act_d;        // duty applied to the PWM comparator
  logic          gate_q, gate_d;
  logic [1:0]    code_q, code_d;

  logic [12:0]   ov_lim;
  logic [12:0]   b_hyst;
  logic [31:0]   dsum;
  logic [1:0]    fc;

  // 13-bit sums so a setpoint near full scale cannot wrap the comparisons.
  assign ov_lim = {1'b0, bus.target_v} + 13'(OV_MARGIN);
  assign b_hyst = {1'b0, bus.data_b} + 13'(HYST);
  assign dsum   = 32'(duty_q) + 32'(DUTY_STEP);

  // Fault priority: overcurrent, overvoltage, then data loss. Sample-based
  // checks only count on new_data; stream health is checked every cycle.
  always_comb begin
    fc = 2'b00;
    if (bus.new_data && (bus.data_a > 12'(OC_LIMIT)))  fc = 2'b01;
    else if (bus.new_data && ({1'b0, bus.data_b} > ov_lim)) fc = 2'b10;
    else if (!bus.valid_data)                           fc = 2'b11;
  end

  always_comb begin
    // Everything outside a continuing CHARGE cycle parks the PWM at zero,
    // which also makes every exit from CHARGE drop the gate next cycle.
    state_d = state_q;
    cnt_d   = '0;
    duty_d  = '0;
    act_d   = '0;
    gate_d  = 1'b0;
    code_d  = code_q;
    unique case (state_q)
      S_IDLE: begin
        code_d = 2'b00;
        if (bus.enable && bus.valid_data) state_d = S_CHARGE;
      end
      S_CHARGE: begin
        if (fc != 2'b00) begin
          state_d = S_FAULT;
          code_d  = fc;
        end else if (!bus.enable) begin
          state_d = S_IDLE;
        end else if (bus.new_data && (bus.data_b >= bus.target_v)) begin
          state_d = S_HOLD;
        end else begin
          gate_d = (cnt_q < act_q);
          cnt_d  = (cnt_q == CW'(PWM_PERIOD - 1)) ? '0 : cnt_q + CW'(1);
          // Applied duty only changes at the period boundary so no pulse is cut.
          act_d  = (cnt_q == CW'(PWM_PERIOD - 1)) ? duty_q : act_q;
          duty_d = duty_q;
          if (bus.new_data)
            duty_d = (dsum >= 32'(MAX_DUTY)) ? CW'(MAX_DUTY) : dsum[CW-1:0];
        end
      end
      S_HOLD: begin
        if (fc != 2'b00) begin
          state_d = S_FAULT;
          code_d  = fc;
        end else if (!bus.enable) begin
          state_d = S_IDLE;
        end else if (bus.new_data && (b_hyst <= {1'b0, bus.target_v})) begin
          state_d = S_CHARGE;
        end
      end
      S_FAULT: begin
        if (!bus.enable) begin
          state_d = S_IDLE;
          code_d  = 2'b00;
        end
      end
      default: begin
        state_d = S_IDLE;
        code_d  = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      duty_q  <= '0;
      act_q   <= '0;
      gate_q  <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      act_q   <= act_d;
      gate_q  <= gate_d;
      code_q  <= code_d;
    end
  end

  assign bus.gate       = gate_q;
  assign bus.charging   = (state_q == S_CHARGE);
  assign bus.at_target  = (state_q == S_HOLD);
  assign bus.fault      = (state_q == S_FAULT);
  assign bus.fault_code = code_q;
endmodule

// File: tb/tb_boost_charge_controller.sv
// Bench for boost_charge_controller: a table of per-cycle vectors, directed
// multi-cycle sequences and random traffic, all checked against a
// behavioural model of the charge rules.
module tb_boost_charge_controller;
  localparam int P   = 100;
  localparam int MD  = 60;
  localparam int ST  = 8;
  localparam int HY  = 20;
  localparam int OC  = 3000;
  localparam int OVM = 100;

  localparam int M_IDLE = 0, M_CHARGE = 1, M_HOLD = 2, M_FAULT = 3;

  logic clk = 1'b0;
  logic rst;
  boost_charge_controller_if bus ();

  boost_charge_controller #(
    .PWM_PERIOD(P), .MAX_DUTY(MD), .DUTY_STEP(ST),
    .HYST(HY), .OC_LIMIT(OC), .OV_MARGIN(OVM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  int m_st, m_pend, m_act, m_cnt, m_gate, m_code;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int min2(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  task automatic m_park();
    m_gate = 0; m_cnt = 0; m_pend = 0; m_act = 0;
  endtask

  // Next-cycle behaviour from current inputs.
  task automatic model_step();
    int f;
    int ng;
    int a, b, tv;
    a  = int'(bus.data_a);
    b  = int'(bus.data_b);
    tv = int'(bus.target_v);
    if (rst) begin
      m_st = M_IDLE; m_code = 0; m_park();
      return;
    end
    f = 0;
    if (bus.new_data && a > OC)            f = 1;
    else if (bus.new_data && b > tv + OVM) f = 2;
    else if (!bus.valid_data)              f = 3;
    case (m_st)
      M_IDLE: begin
        m_park();
        if (bus.enable && bus.valid_data) m_st = M_CHARGE;
      end
      M_CHARGE, M_HOLD: begin
        if (f != 0) begin
          m_st = M_FAULT; m_code = f; m_park();
        end else if (!bus.enable) begin
          m_st = M_IDLE; m_park();
        end else if (m_st == M_CHARGE) begin
          if (bus.new_data && b >= tv) begin
            m_st = M_HOLD; m_park();
          end else begin
            ng = (m_cnt < m_act) ? 1 : 0;
            if (m_cnt == P - 1) m_act = m_pend;
            m_cnt = (m_cnt + 1) % P;
            if (bus.new_data) m_pend = min2(m_pend + ST, MD);
            m_gate = ng;
          end
        end else begin
          m_park();
          if (bus.new_data && b + HY <= tv) m_st = M_CHARGE;
        end
      end
      default: begin
        m_park();
        if (!bus.enable) begin m_st = M_IDLE; m_code = 0; end
      end
    endcase
  endtask

  // One clock: advance model, clock DUT, compare all outputs away from the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("model_outputs",
        {bus.gate, bus.charging, bus.at_target, bus.fault, bus.fault_code},
        {m_gate[0], m_st == M_CHARGE, m_st == M_HOLD, m_st == M_FAULT, m_code[1:0]});
  endtask

  task automatic sample(input int a, input int b);
    bus.new_data = 1'b1;
    bus.data_a   = 12'(a);
    bus.data_b   = 12'(b);
    tick();
    bus.new_data = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic count_gate(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.gate) hi++;
    end
  endtask

  // Bounded wait for a gate pulse; expiry counts as a failed check.
  task automatic wait_gate(input string name);
    int k;
    k = 0;
    while (!bus.gate && k < 2 * P) begin tick(); k++; end
    chk(name, int'(bus.gate), 1);
  endtask

  typedef struct {
    logic r, en;
    logic [11:0] tv;
    logic nd, vd;
    logic [11:0] a, b;
    logic [5:0] exp;   // {gate, charging, at_target, fault, fault_code}
  } vec_t;

  function automatic vec_t mk(input logic r, input logic en, input int tv,
                              input logic nd, input logic vd, input int a,
                              input int b, input logic [5:0] exp);
    vec_t v;
    v.r = r; v.en = en; v.tv = 12'(tv); v.nd = nd; v.vd = vd;
    v.a = 12'(a); v.b = 12'(b); v.exp = exp;
    return v;
  endfunction

  vec_t tbl[27];

  initial begin
    int hi;
    rst = 1'b1;
    bus.enable = 1'b0; bus.target_v = 12'd2000; bus.new_data = 1'b0;
    bus.valid_data = 1'b1; bus.data_a = '0; bus.data_b = '0;
    m_st = M_IDLE; m_code = 0; m_park();

    //             r  en  tv    nd vd  a     b      gate chg hold flt code
    tbl[0]  = mk(1, 0, 2000, 0, 1, 0,    0,    6'b0_0_0_0_00);
    tbl[1]  = mk(0, 1, 2000, 0, 1, 0,    0,    6'b0_1_0_0_00);
    tbl[2]  = mk(0, 1, 2000, 1, 1, 100,  1000, 6'b0_1_0_0_00);
    tbl[3]  = mk(0, 1, 2000, 1, 1, 100,  2000, 6'b0_0_1_0_00);
    tbl[4]  = mk(0, 1, 2000, 1, 1, 100,  1985, 6'b0_0_1_0_00);
    tbl[5]  = mk(0, 1, 2000, 1, 1, 100,  1980, 6'b0_1_0_0_00);
    tbl[6]  = mk(0, 1, 2000, 1, 1, 100,  2101, 6'b0_0_0_1_10);
    tbl[7]  = mk(0, 1, 2000, 1, 1, 3001, 0,    6'b0_0_0_1_10);
    tbl[8]  = mk(0, 0, 2000, 0, 1, 0,    0,    6'b0_0_0_0_00);
    tbl[9]  = mk(0, 1, 2000, 0, 0, 0,    0,    6'b0_0_0_0_00);
    tbl[10] = mk(0, 1, 2000, 0, 1, 0,    0,    6'b0_1_0_0_00);
    tbl[11] = mk(0, 1, 2000, 0, 0, 0,    0,    6'b0_0_0_1_11);
    tbl[12] = mk(0, 0, 2000, 0, 1, 0,    0,    6'b0_0_0_0_00);
    tbl[13] = mk(0, 1, 2000, 0, 1, 0,    0,    6'b0_1_0_0_00);
    tbl[14] = mk(0, 1, 2000, 1, 0, 3001, 2200, 6'b0_0_0_1_01);
    tbl[15] = mk(0, 0, 2000, 0, 1, 0,    0,    6'b0_0_0_0_00);
    tbl[16] = mk(0, 1, 2000, 0, 1, 0,    0,    6'b0_1_0_0_00);
    tbl[17] = mk(0, 1, 2000, 1, 0, 100,  2101, 6'b0_0_0_1_10);
    tbl[18] = mk(0, 0, 2000, 0, 1, 0,    0,    6'b0_0_0_0_00);
    tbl[19] = mk(0, 1, 4095, 0, 1, 0,    0,    6'b0_1_0_0_00);
    tbl[20] = mk(0, 1, 4095, 1, 1, 0,    4095, 6'b0_0_1_0_00);
    tbl[21] = mk(0, 1, 10,   1, 1, 0,    0,    6'b0_0_1_0_00);
    tbl[22] = mk(0, 1, 20,   1, 1, 0,    0,    6'b0_1_0_0_00);
    tbl[23] = mk(0, 1, 2000, 1, 1, 3000, 0,    6'b0_1_0_0_00);
    tbl[24] = mk(0, 1, 2000, 1, 1, 3001, 0,    6'b0_0_0_1_01);
    tbl[25] = mk(1, 1, 2000, 1, 1, 0,    0,    6'b0_0_0_0_00);
    tbl[26] = mk(0, 1, 2000, 0, 1, 0,    0,    6'b0_1_0_0_00);

    for (int i = 0; i < 27; i++) begin
      rst = tbl[i].r; bus.enable = tbl[i].en; bus.target_v = tbl[i].tv;
      bus.new_data = tbl[i].nd; bus.valid_data = tbl[i].vd;
      bus.data_a = tbl[i].a; bus.data_b = tbl[i].b;
      tick();
      chk($sformatf("table_row%0d", i),
          {bus.gate, bus.charging, bus.at_target, bus.fault, bus.fault_code},
          tbl[i].exp);
    end
    bus.new_data = 1'b0;

    // Ramp: high-time over a full period tracks 8,16,... and saturates.
    rst = 1'b1; tick(); rst = 1'b0;
    bus.enable = 1'b1; bus.valid_data = 1'b1; bus.target_v = 12'd2000;
    tick();
    for (int n = 1; n <= 10; n++) begin
      sample(100, 1000);
      hi = 0;
      for (int c = 1; c <= 2 * P; c++) begin
        tick();
        if (c > P && bus.gate) hi++;
      end
      chk($sformatf("ramp_duty_n%0d", n), hi, min2(n * ST, MD));
    end

    // Regulation with hysteresis
    wait_gate("reg_gate_seen");
    sample(100, 2000);
    chk("reg_hold_gate", int'(bus.gate), 0);
    chk("reg_at_target", int'(bus.at_target), 1);
    sample(100, 1985);
    chk("reg_stay_hold", int'(bus.at_target), 1);
    sample(100, 1980);
    chk("reg_recharge", int'(bus.charging), 1);
    count_gate(2 * P, hi);
    chk("reg_duty_restart", hi, 0);

    // Overcurrent with simultaneous overvoltage
    sample(100, 1000); sample(100, 1000);
    run(2 * P);
    wait_gate("oc_gate_seen");
    sample(3001, 2200);
    chk("oc_fault", int'(bus.fault), 1);
    chk("oc_code", int'(bus.fault_code), 1);
    chk("oc_gate", int'(bus.gate), 0);
    bus.enable = 1'b0; tick();
    chk("oc_clear_code", int'(bus.fault_code), 0);
    chk("oc_clear_fault", int'(bus.fault), 0);

    // Data loss in HOLD; samples ignored while faulted
    bus.enable = 1'b1; tick();
    sample(100, 2000);
    chk("dl_hold", int'(bus.at_target), 1);
    bus.valid_data = 1'b0; tick(); bus.valid_data = 1'b1;
    chk("dl_code", int'(bus.fault_code), 3);
    sample(3001, 4095); sample(100, 1000); run(3);
    chk("dl_ignore_nd", int'(bus.fault_code), 3);
    chk("dl_still_fault", int'(bus.fault), 1);
    bus.enable = 1'b0; tick(); bus.enable = 1'b1; tick();

    // Reset mid-period with gate high
    sample(100, 1000); sample(100, 1000); sample(100, 1000);
    run(2 * P);
    wait_gate("rst_gate_seen");
    rst = 1'b1; tick();
    chk("rst_outputs", {bus.gate, bus.charging, bus.at_target, bus.fault, bus.fault_code}, 0);
    rst = 1'b0; tick();
    chk("rst_recharge", int'(bus.charging), 1);
    count_gate(2 * P, hi);
    chk("rst_duty_zero", hi, 0);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      int tv;
      rst            = ($urandom_range(0, 799) == 0);
      bus.enable     = ($urandom_range(0, 299) != 0);
      bus.valid_data = ($urandom_range(0, 399) != 0);
      bus.new_data   = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 499) == 0) bus.target_v = 12'($urandom_range(1500, 2500));
      tv = int'(bus.target_v);
      bus.data_a = ($urandom_range(0, 19) == 0) ? 12'($urandom_range(2998, 3002))
                                                : 12'($urandom_range(0, 2500));
      case ($urandom_range(0, 3))
        0:       bus.data_b = 12'($urandom_range(tv - 30, tv + 5));
        1:       bus.data_b = 12'($urandom_range(tv + 95, tv + 105));
        default: bus.data_b = 12'($urandom_range(0, tv - 200));
      endcase
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
